alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
- REQ-001 SHALL provide parameter WIDTH, default 8, datapath width in bits; legal values are multiples of 4, minimum 4.
- REQ-002 SHALL provide parameter DECIMAL_EN, default 1; 1 enables BCD add/sub, 0 forces binary regardless of the decimal input.
- REQ-003 clk  input  1  single clock; all state updates on rising edge.
- REQ-004 reset  input  1  synchronous, active-high reset.
- REQ-005 in_valid  input  1  operation request valid.
- REQ-006 in_ready  output  1  block can accept a request this cycle.
- REQ-007 op  input  4  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 EOR, 5 ASL, 6 LSR, 7 ROL, 8 ROR, 9 CMP; 10-15 reserved.
- REQ-008 a, b  input  WIDTH  operands.
- REQ-009 carry_in  input  1  carry / not-borrow / rotate-in bit.
- REQ-010 decimal  input  1  BCD mode for ADD/SUB.
- REQ-011 out_valid  output  1  result and flags valid.
- REQ-012 out_ready  input  1  consumer accepts the result.
- REQ-013 result  output  WIDTH  registered result.
- REQ-014 carry_out, overflow, zero, sign  output  1 each  registered C, V, Z, N flags.

Function
- REQ-015 SHALL implement FSM states IDLE, CALC, ADJ, DONE; in_ready = 1 only in IDLE.
- REQ-016 SHALL capture op, a, b, carry_in and decimal on the cycle in_valid && in_ready (the accept cycle N), then move to CALC.
- REQ-017 CALC SHALL compute a (WIDTH+1)-bit sum; go to ADJ for decimal ADD/SUB with DECIMAL_EN=1, otherwise load the outputs and go to DONE.
- REQ-018 Latency SHALL be: out_valid high at cycle N+2 for binary ops and N+3 for decimal ops.
- REQ-019 ADD SHALL compute a+b+carry_in; C = bit WIDTH; V = (a[W-1]==b[W-1]) && (r[W-1]!=a[W-1]).
- REQ-020 SUB SHALL compute a+~b+carry_in; C = 1 means no borrow; V as for ADD using ~b.
- REQ-021 CMP SHALL compute a+~b+1, ignoring carry_in; C, Z and N follow the difference; V = 0.
- REQ-022 AND, OR, EOR SHALL pass C = carry_in and force V = 0.
- REQ-023 ASL: r = a<<1, C = a[W-1]. LSR: r = a>>1, C = a[0]. ROL: r = {a[W-2:0], carry_in}, C = a[W-1]. ROR: r = {carry_in, a[W-1:1]}, C = a[0]. V = 0 for all four.
- REQ-024 Reserved ops SHALL give r = a, C = carry_in, V = 0.
- REQ-025 For all ops, Z = (result == 0) and N = result[W-1], taken from the final (adjusted) result.
- REQ-026 ADJ SHALL correct the result per nibble, least significant first, with carry propagated between digits.
  - ADD: add 6 to a digit when it is >9 or produced a carry.
  - SUB: subtract 6 from a digit when it produced a borrow.
  - C = decimal carry (ADD) or not-borrow (SUB) out of the top digit; V taken from the binary intermediate.
- REQ-027 Non-BCD digits in decimal mode SHALL produce a deterministic result using the same rule; no error is flagged.
- REQ-028 In DONE, out_valid SHALL stay high and all outputs SHALL stay stable until out_ready = 1.
- REQ-029 In DONE with out_ready = 1, the FSM SHALL return to IDLE; in_ready rises on the next cycle (one bubble between operations).
- REQ-030 in_valid while in_ready = 0 SHALL be ignored; the requester holds the request.
- REQ-031 out_ready while out_valid = 0 SHALL have no effect.

Reset
- REQ-032 With reset high at a clock edge, the next state SHALL be IDLE with out_valid = 0, in_ready = 1, result = 0, and all flags = 0, from any state.
- REQ-033 An operation in flight at reset SHALL be discarded with no out_valid pulse.
- REQ-034 Reset SHALL take priority over a simultaneous in_valid or out_ready.

Verification (WIDTH=8)
- REQ-035 ADD a=0x50, b=0x50, cin=0 -> result 0xA0, C0 V1 N1 Z0, out_valid at N+2.
- REQ-036 SUB a=0x00, b=0x01, cin=1 -> 0xFF, C0 V0 N1 Z0; CMP a=0x42, b=0x42 -> 0x00, C1 Z1.
- REQ-037 Decimal ADD a=0x58, b=0x46, cin=1 -> 0x05, C1, out_valid at N+3; decimal SUB a=0x46, b=0x12, cin=1 -> 0x34, C1.
- REQ-038 ROR a=0x01, cin=1 -> 0x80, C1 N1; ASL a=0x80 -> 0x00, C1 Z1.
- REQ-039 Hold out_ready=0 for 3 cycles in DONE -> result and flags unchanged, in_ready=0; out_ready=1 -> in_ready=1 on the next cycle.
- REQ-040 Assert reset during ADJ -> next cycle out_valid=0, in_ready=1, result=0x00, all flags 0, no result delivered.

Source files
------------

// File: rtl/alu_seq.sv
// Multi-cycle ALU (binary/BCD add-sub, logic, shifts, compare) with a registered result and C/V/Z/N flags.
// Result valid 2 cycles after accept (3 for BCD add/sub); result holds in DONE until out_ready, then one idle bubble.
module alu_seq #(
    parameter int WIDTH      = 8,
    parameter bit DECIMAL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             decimal,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             sign
);
    localparam int DIGITS = WIDTH / 4;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_EOR = 4'd4;
    localparam logic [3:0] OP_ASL = 4'd5;
    localparam logic [3:0] OP_LSR = 4'd6;
    localparam logic [3:0] OP_ROL = 4'd7;
    localparam logic [3:0] OP_ROR = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;

    typedef enum logic [1:0] {IDLE, CALC, ADJ, DONE} state_t;

    typedef struct packed {
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             dec;
    } req_t;

    state_t           state;
    req_t             req;
    logic             vbin;

    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic [WIDTH:0]   sum;
    logic             arith_v;
    logic [WIDTH-1:0] calc_res;
    logic             calc_c;
    logic             calc_v;
    logic             to_adj;

    logic [WIDTH-1:0] dec_res;
    logic             dec_c;
    logic [3:0]       da;
    logic [3:0]       db;
    logic [4:0]       dsum;

    assign in_ready = (state == IDLE);

    // SUB and CMP share the inverted-operand adder; CMP always injects a carry.
    assign b_eff   = (req.op == OP_ADD) ? req.b : ~req.b;
    assign c_eff   = (req.op == OP_CMP) ? 1'b1 : req.cin;
    assign sum     = {1'b0, req.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c_eff};
    assign arith_v = (req.a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != req.a[WIDTH-1]);
    assign to_adj  = DECIMAL_EN && req.dec && ((req.op == OP_ADD) || (req.op == OP_SUB));

    always_comb begin
        calc_res = req.a;
        calc_c   = req.cin;
        calc_v   = 1'b0;
        case (req.op)
            OP_ADD, OP_SUB: begin
                calc_res = sum[WIDTH-1:0];
                calc_c   = sum[WIDTH];
                calc_v   = arith_v;
            end
            OP_CMP: begin
                calc_res = sum[WIDTH-1:0];
                calc_c   = sum[WIDTH];
            end
            OP_AND: calc_res = req.a & req.b;
            OP_OR:  calc_res = req.a | req.b;
            OP_EOR: calc_res = req.a ^ req.b;
            OP_ASL: begin
                calc_res = {req.a[WIDTH-2:0], 1'b0};
                calc_c   = req.a[WIDTH-1];
            end
            OP_LSR: begin
                calc_res = {1'b0, req.a[WIDTH-1:1]};
                calc_c   = req.a[0];
            end
            OP_ROL: begin
                calc_res = {req.a[WIDTH-2:0], req.cin};
                calc_c   = req.a[WIDTH-1];
            end
            OP_ROR: begin
                calc_res = {req.cin, req.a[WIDTH-1:1]};
                calc_c   = req.a[0];
            end
            default: ;
        endcase
    end

    // Digit-serial BCD correction; carry (ADD) or not-borrow (SUB) ripples low digit to high.
    always_comb begin
        dec_res = '0;
        dec_c   = req.cin;
        da      = '0;
        db      = '0;
        dsum    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            da   = req.a[4*i +: 4];
            db   = (req.op == OP_SUB) ? ~req.b[4*i +: 4] : req.b[4*i +: 4];
            dsum = {1'b0, da} + {1'b0, db} + {4'b0000, dec_c};
            if (req.op == OP_SUB) begin
                dec_c              = dsum[4];
                dec_res[4*i +: 4]  = dsum[4] ? dsum[3:0] : dsum[3:0] - 4'd6;
            end else begin
                dec_c              = (dsum > 5'd9);
                dec_res[4*i +: 4]  = (dsum > 5'd9) ? dsum[3:0] + 4'd6 : dsum[3:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            req       <= '0;
            vbin      <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            sign      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        req.op  <= op;
                        req.a   <= a;
                        req.b   <= b;
                        req.cin <= carry_in;
                        req.dec <= decimal;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    vbin <= calc_v;
                    if (to_adj) begin
                        state <= ADJ;
                    end else begin
                        result    <= calc_res;
                        carry_out <= calc_c;
                        overflow  <= calc_v;
                        zero      <= (calc_res == '0);
                        sign      <= calc_res[WIDTH-1];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                ADJ: begin
                    result    <= dec_res;
                    carry_out <= dec_c;
                    overflow  <= vbin;
                    zero      <= (dec_res == '0);
                    sign      <= dec_res[WIDTH-1];
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vectors, random ops against an arithmetic model, flow control and reset.
module tb_alu_seq;
    localparam int W    = 8;
    localparam int FULL = 1 << W;
    localparam int HALF = FULL / 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         carry_in = 1'b0;
    logic         decimal = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         carry_out, overflow, zero, sign;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] got_res;
    logic         got_c, got_v, got_z, got_n;
    int           got_lat;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         v;
        logic         z;
        logic         n;
        logic [3:0]   lat;
    } exp_t;

    typedef struct packed {
        logic [3:0]   o;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         ci;
        logic         dc;
        exp_t         e;
    } vec_t;

    alu_seq #(.WIDTH(W), .DECIMAL_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .carry_in(carry_in), .decimal(decimal),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .carry_out(carry_out), .overflow(overflow), .zero(zero), .sign(sign)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: signed/unsigned integer arithmetic and decimal digit loop.
    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic dc);
        exp_t e;
        int ai, bi, cv, sa, sb, s, vs, rr, cc, vv, t, dcar, dres, ad, bd, lat;
        ai  = int'(x);
        bi  = int'(y);
        cv  = ci ? 1 : 0;
        sa  = (ai >= HALF) ? ai - FULL : ai;
        sb  = (bi >= HALF) ? bi - FULL : bi;
        rr  = ai;
        cc  = cv;
        vv  = 0;
        lat = 2;
        case (o)
            4'd0: begin
                s = ai + bi + cv; rr = s % FULL; cc = (s >= FULL) ? 1 : 0;
                vs = sa + sb + cv; vv = (vs < -HALF || vs >= HALF) ? 1 : 0;
            end
            4'd1: begin
                s = ai - bi - 1 + cv; rr = (s + FULL) % FULL; cc = (s >= 0) ? 1 : 0;
                vs = sa - sb - 1 + cv; vv = (vs < -HALF || vs >= HALF) ? 1 : 0;
            end
            4'd2: rr = ai & bi;
            4'd3: rr = ai | bi;
            4'd4: rr = ai ^ bi;
            4'd5: begin rr = (ai * 2) % FULL; cc = (ai >= HALF) ? 1 : 0; end
            4'd6: begin rr = ai / 2; cc = ai % 2; end
            4'd7: begin rr = (ai * 2) % FULL + cv; cc = (ai >= HALF) ? 1 : 0; end
            4'd8: begin rr = ai / 2 + cv * HALF; cc = ai % 2; end
            4'd9: begin rr = (ai - bi + FULL) % FULL; cc = (ai >= bi) ? 1 : 0; end
            default: ;
        endcase
        if (dc && (o == 4'd0 || o == 4'd1)) begin
            dcar = cv;
            dres = 0;
            for (int d = 0; d < W / 4; d++) begin
                ad = (ai >> (4 * d)) & 15;
                bd = (bi >> (4 * d)) & 15;
                if (o == 4'd0) begin
                    t = ad + bd + dcar;
                    if (t > 9) begin t = t + 6; dcar = 1; end else dcar = 0;
                end else begin
                    t = ad - bd - (1 - dcar);
                    if (t < 0) begin t = t - 6; dcar = 0; end else dcar = 1;
                end
                dres = dres + ((((t % 16) + 16) % 16) << (4 * d));
            end
            rr  = dres;
            cc  = dcar;
            lat = 3;
        end
        e.r   = rr[W-1:0];
        e.c   = (cc != 0);
        e.v   = (vv != 0);
        e.z   = (rr == 0);
        e.n   = (rr >= HALF);
        e.lat = 4'(lat);
        return e;
    endfunction

    task automatic issue_and_wait(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic ci, input logic dc);
        int k;
        @(negedge clk);
        op = o; a = x; b = y; carry_in = ci; decimal = dc; in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        got_lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got_lat = i;
                break;
            end
        end
        got_res = result; got_c = carry_out; got_v = overflow; got_z = zero; got_n = sign;
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b1;
        op = 4'd0; a = 8'h11; b = 8'h22;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++;
        if (result !== 8'h00) $display("FAIL reset_result: got %h want 00", result); else n_pass++;
        n_checks++;
        if ({carry_out, overflow, zero, sign} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000", {carry_out, overflow, zero, sign});
        else n_pass++;
        in_valid = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_directed();
        vec_t tv[13];
        tv[0]  = '{4'd0, 8'h50, 8'h50, 1'b0, 1'b0, '{8'hA0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2}};
        tv[1]  = '{4'd1, 8'h00, 8'h01, 1'b1, 1'b0, '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2}};
        tv[2]  = '{4'd9, 8'h42, 8'h42, 1'b0, 1'b0, '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2}};
        tv[3]  = '{4'd0, 8'h58, 8'h46, 1'b1, 1'b1, '{8'h05, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3}};
        tv[4]  = '{4'd1, 8'h46, 8'h12, 1'b1, 1'b1, '{8'h34, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3}};
        tv[5]  = '{4'd8, 8'h01, 8'h00, 1'b1, 1'b0, '{8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2}};
        tv[6]  = '{4'd5, 8'h80, 8'h00, 1'b0, 1'b0, '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2}};
        tv[7]  = '{4'd12, 8'h3C, 8'h00, 1'b1, 1'b0, '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2}};
        tv[8]  = '{4'd2, 8'hF0, 8'h3C, 1'b1, 1'b1, '{8'h30, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2}};
        tv[9]  = '{4'd7, 8'h81, 8'h00, 1'b0, 1'b0, '{8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2}};
        tv[10] = '{4'd6, 8'h01, 8'h00, 1'b0, 1'b0, '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2}};
        tv[11] = '{4'd4, 8'hFF, 8'h0F, 1'b0, 1'b0, '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2}};
        tv[12] = '{4'd3, 8'h00, 8'h00, 1'b0, 1'b0, '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2}};
        for (int i = 0; i < 13; i++) begin
            issue_and_wait(tv[i].o, tv[i].x, tv[i].y, tv[i].ci, tv[i].dc);
            n_checks++;
            if ({got_res, got_c, got_v, got_z, got_n} !== {tv[i].e.r, tv[i].e.c, tv[i].e.v, tv[i].e.z, tv[i].e.n})
                $display("FAIL directed_%0d value: got r=%h cvzn=%b%b%b%b want r=%h cvzn=%b%b%b%b", i,
                         got_res, got_c, got_v, got_z, got_n,
                         tv[i].e.r, tv[i].e.c, tv[i].e.v, tv[i].e.z, tv[i].e.n);
            else n_pass++;
            n_checks++;
            if (got_lat !== int'(tv[i].e.lat))
                $display("FAIL directed_%0d latency: got %0d want %0d", i, got_lat, tv[i].e.lat);
            else n_pass++;
            release_result();
        end
    endtask

    task automatic test_random();
        exp_t         e;
        logic [3:0]   o;
        logic [W-1:0] x, y;
        logic         ci, dc;
        for (int i = 0; i < 40; i++) begin
            o  = 4'($urandom_range(0, 15));
            x  = W'($urandom);
            y  = W'($urandom);
            ci = 1'($urandom);
            dc = 1'($urandom);
            e  = model(o, x, y, ci, dc);
            issue_and_wait(o, x, y, ci, dc);
            n_checks++;
            if ({got_res, got_c, got_v, got_z, got_n} !== {e.r, e.c, e.v, e.z, e.n})
                $display("FAIL random_%0d op=%0d a=%h b=%h cin=%b dec=%b: got r=%h cvzn=%b%b%b%b want r=%h cvzn=%b%b%b%b",
                         i, o, x, y, ci, dc, got_res, got_c, got_v, got_z, got_n, e.r, e.c, e.v, e.z, e.n);
            else n_pass++;
            n_checks++;
            if (got_lat !== int'(e.lat))
                $display("FAIL random_%0d latency: got %0d want %0d", i, got_lat, e.lat);
            else n_pass++;
            release_result();
        end
    endtask

    task automatic test_backpressure();
        exp_t         e;
        logic [W+3:0] snap;
        e = model(4'd0, 8'h27, 8'h35, 1'b0, 1'b1);
        issue_and_wait(4'd0, 8'h27, 8'h35, 1'b0, 1'b1);
        n_checks++;
        if ({got_res, got_c, got_v, got_z, got_n} !== {e.r, e.c, e.v, e.z, e.n})
            $display("FAIL hold_value: got %h want %h", {got_res, got_c, got_v, got_z, got_n}, {e.r, e.c, e.v, e.z, e.n});
        else n_pass++;
        snap = {e.r, e.c, e.v, e.z, e.n};
        op = 4'd3; a = 8'h0F; b = 8'hF0; carry_in = 1'b0; decimal = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({result, carry_out, overflow, zero, sign, out_valid, in_ready} !== {snap, 1'b1, 1'b0})
                $display("FAIL hold_cycle_%0d: got %h want %h", i,
                         {result, carry_out, overflow, zero, sign, out_valid, in_ready}, {snap, 1'b1, 1'b0});
            else n_pass++;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL release_ready: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        else n_pass++;
        @(posedge clk);
        #1 in_valid = 1'b0;
        got_lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got_lat = i;
                break;
            end
        end
        n_checks++;
        if ({got_lat, result, carry_out, overflow, zero, sign} !== {32'd2, 8'hFF, 4'b0001})
            $display("FAIL held_request: got lat=%0d r=%h cvzn=%b%b%b%b want lat=2 r=ff cvzn=0001",
                     got_lat, result, carry_out, overflow, zero, sign);
        else n_pass++;
        release_result();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] x, y;
        logic         exp_v, exp_r;
        x = W'($urandom);
        y = W'($urandom);
        @(negedge clk);
        op = 4'd4; a = x; b = y; carry_in = 1'b0; decimal = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            exp_v = (i % 3 == 2);
            exp_r = (i % 3 == 0);
            n_checks++;
            if ({out_valid, in_ready} !== {exp_v, exp_r})
                $display("FAIL b2b_cycle_%0d: got valid=%b ready=%b want valid=%b ready=%b",
                         i, out_valid, in_ready, exp_v, exp_r);
            else n_pass++;
            if (exp_v) begin
                n_checks++;
                if (result !== (x ^ y)) $display("FAIL b2b_result_%0d: got %h want %h", i, result, x ^ y);
                else n_pass++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset_midflight();
        int seen;
        @(negedge clk);
        op = 4'd0; a = 8'h58; b = 8'h46; carry_in = 1'b1; decimal = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({out_valid, in_ready, result, carry_out, overflow, zero, sign} !== {2'b01, 8'h00, 4'b0000})
            $display("FAIL adj_reset: got valid=%b ready=%b r=%h cvzn=%b%b%b%b want valid=0 ready=1 r=00 cvzn=0000",
                     out_valid, in_ready, result, carry_out, overflow, zero, sign);
        else n_pass++;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) $display("FAIL adj_reset_discard: got %0d valid cycles want 0", seen);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
